cmos_dvp_tx: RTL and testbench
==============================

// Module: cmos_dvp_tx
// PURPOSE
//  DVP sensor-side transmitter: produces cmos_vsync/cmos_href/cmos_data (8-bit, RGB565, 2 bytes/pixel,
//  high byte first) on cmos_pclk. It is the driving end of the camera capture interface, used for
//  sensor-free bring-up, loopback and simulation. Pixels come from an upstream valid/ready stream
//  or from an internal 8-bar colour pattern.
// PARAMETERS
//  H_DISP   1280  active pixels per line (2*H_DISP bytes with href high)
//  V_DISP   720   active lines per frame
//  VS_CYC   1000  vsync high width, pclk cycles
//  VBP_CYC  1000  cycles from vsync fall to first href rise
//  HB_CYC   320   href-low cycles between lines (>=2)
//  VFP_CYC  1000  cycles after last line before next vsync rise
// PORTS
//  cmos_pclk   in   1   pixel clock; all logic on rising edge
//  rst_n       in   1   async active-low reset
//  tx_en       in   1   level; start/continue frames while high
//  pat_sel     in   1   0 = external stream, 1 = colour bars; sampled at vsync rise
//  pix_data    in   16  RGB565 pixel from upstream
//  pix_valid   in   1   pix_data valid
//  pix_ready   out  1   transmitter takes a pixel this cycle (combinational)
//  cmos_vsync  out  1   frame sync, active high pulse
//  cmos_href   out  1   line valid, high for 2*H_DISP cycles per line
//  cmos_data   out  8   byte bus, valid while cmos_href high
//  frame_start out  1   1-cycle pulse with vsync rise
//  frame_done  out  1   1-cycle pulse on first cycle after last byte of last line
//  underrun    out  1   sticky: external pixel missing in current frame; cleared at frame_start
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-frame aborts immediately; no partial resume.
//  - FSM: IDLE -> VSYNC (tx_en=1) -> VBP -> ACTIVE -> HBLANK -> ACTIVE ... -> VFP -> VSYNC (tx_en=1) | IDLE.
//  - VSYNC VS_CYC cycles, VBP VBP_CYC, HBLANK HB_CYC, VFP VFP_CYC; 16-bit cycle counter, reloaded per state.
//  - ACTIVE: byte phase ph toggles each cycle; h_cnt (12b) counts pixels 0..H_DISP-1, v_cnt (11b) lines 0..V_DISP-1.
//    After pixel H_DISP-1 low byte: v_cnt==V_DISP-1 -> VFP, else HBLANK and v_cnt++.
//  - tx_en low mid-frame: current frame completes through VFP, then IDLE. tx_en sampled only in VFP/IDLE.
//  - Outputs are registered: cmos_href/cmos_data change together; no glitch on vsync/href.
//  - pix_ready = ACTIVE & ph==0 & pat_sel_q==0. Pixel captured when pix_valid&pix_ready; high byte
//    driven next cycle, low byte the cycle after (latency 1 cycle to first byte).
//  - pix_ready high with pix_valid low: transmit 16'h0000, set underrun; line timing never stalls.
//  - pix_valid without pix_ready: ignored (upstream holds).
//  - Colour bars: bar = h_cnt / (H_DISP/8); colours FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000
//    (white,yellow,cyan,green,magenta,red,blue,black). H_DISP must be a multiple of 8.
//  - pat_sel changes mid-frame take effect at next vsync rise.
//  - frame_done and frame_start may not coincide (VFP_CYC>=1 guarantees separation).
//  - cmos_data = 8'h00 while cmos_href low.
// STRUCTURE
//  - Shared include cmos_defs.vh: FSM state encodings, RGB565 colour-bar constants, default timing values.
//  - Sub-module cmos_colorbar_gen: h_cnt -> 16-bit pixel, purely combinational + bar-width compare.
//  - Top holds FSM, cycle/h/v counters, byte serializer, output registers.
// TESTING (bench params H_DISP=8, V_DISP=4, VS_CYC=4, VBP_CYC=3, HB_CYC=2, VFP_CYC=3)
//  1 Reset then tx_en=1, pat_sel=1 -> vsync high 4 cycles, href rises 3 cycles after vsync fall,
//    4 lines of 16 bytes: FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; HB gap 2 cycles.
//  2 pat_sel=0, upstream always valid with pixels 0x0100..0x011F -> bytes 01,00,01,01,...; pix_ready
//    pulses 32 times per frame; underrun stays 0; frame_done one cycle after last byte 0x1F.
//  3 Drop pix_valid for pixel 5 of line 2 -> bytes 00,00 at that slot, underrun=1 until next frame_start.
//  4 Deassert tx_en during line 1 -> frame completes (4 lines), VFP 3 cycles, then IDLE, vsync stays 0.
//  5 Assert rst_n=0 mid-line -> vsync/href/data/pix_ready 0 asynchronously; after release new frame
//    starts from vsync only when tx_en=1.
//  6 Loopback into capture block with same H/V params -> received frame matches sent pattern, one eop per frame.

Source files
------------

// File: rtl/cmos_dvp_tx_pkg.sv
// Shared definitions for the DVP sensor-side transmitter: FSM states, bus
// widths, default frame timing and the RGB565 colour-bar palette.
package cmos_dvp_tx_pkg;

  localparam int unsigned CYC_W    = 16;  // per-state cycle counter
  localparam int unsigned H_W      = 12;  // pixel-in-line counter
  localparam int unsigned V_W      = 11;  // line-in-frame counter
  localparam int unsigned BYTE_W   = 8;   // DVP data bus
  localparam int unsigned NUM_BARS = 8;

  localparam int unsigned DEF_H_DISP  = 1280;
  localparam int unsigned DEF_V_DISP  = 720;
  localparam int unsigned DEF_VS_CYC  = 1000;
  localparam int unsigned DEF_VBP_CYC = 1000;
  localparam int unsigned DEF_HB_CYC  = 320;
  localparam int unsigned DEF_VFP_CYC = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // White, yellow, cyan, green, magenta, red, blue, black
  function automatic rgb565_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cmos_dvp_tx_if.sv
// Upstream pixel stream (valid/ready) feeding the DVP transmitter.
//   pix_data  : RGB565 pixel
//   pix_valid : pix_data holds a pixel
//   pix_ready : transmitter takes the pixel this cycle (combinational)
interface cmos_dvp_tx_if;
  import cmos_dvp_tx_pkg::*;

  rgb565_t pix_data;
  logic    pix_valid;
  logic    pix_ready;

  modport master (output pix_data, output pix_valid, input  pix_ready);
  modport slave  (input  pix_data, input  pix_valid, output pix_ready);
endinterface

// File: rtl/cmos_colorbar_gen.sv
// 8-bar colour pattern: maps the pixel index within a line to an RGB565 colour.
//   h_cnt : pixel index 0..H_DISP-1
//   pixel : colour of the bar containing h_cnt
// H_DISP must be a multiple of 8.
module cmos_colorbar_gen
  import cmos_dvp_tx_pkg::*;
#(
  parameter int unsigned H_DISP = DEF_H_DISP
) (
  input  logic [H_W-1:0] h_cnt,
  output rgb565_t        pixel
);

  localparam int unsigned BAR_W = H_DISP / NUM_BARS;

  logic [2:0] bar;

  // Bar index by threshold compare instead of a divider
  always_comb begin
    bar = 3'd0;
    for (int unsigned k = 1; k < NUM_BARS; k++) begin
      if (h_cnt >= H_W'(k * BAR_W)) bar = 3'(k);
    end
    pixel = bar_color(bar);
  end

endmodule

// File: rtl/cmos_dvp_tx.sv
// DVP sensor-side transmitter: drives cmos_vsync/cmos_href/cmos_data
// (RGB565, two bytes per pixel, high byte first) from an upstream pixel stream
// or an internal colour-bar pattern.
//   cmos_pclk, rst_n : clock, async active-low reset
//   tx_en            : keep producing frames while high (sampled in IDLE/VFP)
//   pat_sel          : 0 = stream, 1 = colour bars (sampled at vsync rise)
//   pix              : upstream valid/ready pixel stream (slave side)
//   cmos_vsync/href/data : registered DVP bus
//   frame_start/frame_done : 1-cycle frame markers
//   underrun         : sticky, a stream pixel was missing in this frame
module cmos_dvp_tx
  import cmos_dvp_tx_pkg::*;
#(
  parameter int unsigned H_DISP  = DEF_H_DISP,
  parameter int unsigned V_DISP  = DEF_V_DISP,
  parameter int unsigned VS_CYC  = DEF_VS_CYC,
  parameter int unsigned VBP_CYC = DEF_VBP_CYC,
  parameter int unsigned HB_CYC  = DEF_HB_CYC,
  parameter int unsigned VFP_CYC = DEF_VFP_CYC
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              pat_sel,
  cmos_dvp_tx_if.slave      pix,
  output logic              cmos_vsync,
  output logic              cmos_href,
  output logic [BYTE_W-1:0] cmos_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              underrun
);

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cyc_cnt, cyc_lim;
  logic             cyc_last;
  logic             ph;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             h_last, v_last;
  logic             pat_sel_q;
  rgb565_t          bar_pix;
  logic [15:0]      pix_word;
  logic [7:0]       lo_hold;
  logic             ready_c, line_end, vs_enter, starve, fs_cond, fd_cond;

  assign h_last = (h_cnt == H_W'(H_DISP - 1));
  assign v_last = (v_cnt == V_W'(V_DISP - 1));

  cmos_colorbar_gen #(.H_DISP(H_DISP)) u_colorbar (
    .h_cnt (h_cnt),
    .pixel (bar_pix)
  );

  // State register
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; timed states leave on the last cycle of their window
  always_comb begin
    state_nxt = state;
    cyc_lim   = '0;
    case (state)
      ST_VSYNC:  cyc_lim = CYC_W'(VS_CYC - 1);
      ST_VBP:    cyc_lim = CYC_W'(VBP_CYC - 1);
      ST_HBLANK: cyc_lim = CYC_W'(HB_CYC - 1);
      ST_VFP:    cyc_lim = CYC_W'(VFP_CYC - 1);
      default:   cyc_lim = '0;
    endcase
    cyc_last = (cyc_cnt == cyc_lim);
    case (state)
      ST_IDLE:   if (tx_en)       state_nxt = ST_VSYNC;
      ST_VSYNC:  if (cyc_last)    state_nxt = ST_VBP;
      ST_VBP:    if (cyc_last)    state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (ph && h_last) state_nxt = v_last ? ST_VFP : ST_HBLANK;
      ST_HBLANK: if (cyc_last)    state_nxt = ST_ACTIVE;
      ST_VFP:    if (cyc_last)    state_nxt = tx_en ? ST_VSYNC : ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle strobes and pixel source selection
  always_comb begin
    ready_c  = (state == ST_ACTIVE) && !ph && !pat_sel_q;
    line_end = (state == ST_ACTIVE) && ph && h_last;
    vs_enter = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);
    starve   = ready_c && !pix.pix_valid;
    fs_cond  = (state == ST_VSYNC) && (cyc_cnt == '0);
    fd_cond  = (state == ST_VFP) && (cyc_cnt == '0);
    pix_word = 16'h0000;
    if (pat_sel_q)          pix_word = bar_pix;
    else if (pix.pix_valid) pix_word = pix.pix_data;
  end

  assign pix.pix_ready = ready_c;

  // Timing counters and pixel low-byte holding register
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt   <= '0;
      ph        <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      pat_sel_q <= 1'b0;
      lo_hold   <= '0;
    end else begin
      if (state_nxt != state)
        cyc_cnt <= '0;
      else if (state != ST_IDLE && state != ST_ACTIVE)
        cyc_cnt <= cyc_cnt + CYC_W'(1);
      ph <= (state == ST_ACTIVE) ? ~ph : 1'b0;
      if (state == ST_ACTIVE && ph)
        h_cnt <= h_last ? '0 : h_cnt + H_W'(1);
      if (line_end)
        v_cnt <= v_last ? '0 : v_cnt + V_W'(1);
      if (vs_enter)
        pat_sel_q <= pat_sel;
      if (state == ST_ACTIVE && !ph)
        lo_hold <= pix_word[7:0];
    end
  end

  // Registered DVP outputs: bus lags the FSM by one cycle so the high byte
  // of a pixel accepted in cycle N appears in cycle N+1
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_vsync  <= 1'b0;
      cmos_href   <= 1'b0;
      cmos_data   <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cmos_vsync  <= (state == ST_VSYNC);
      cmos_href   <= (state == ST_ACTIVE);
      if (state != ST_ACTIVE) cmos_data <= '0;
      else if (ph)            cmos_data <= lo_hold;
      else                    cmos_data <= pix_word[15:8];
      frame_start <= fs_cond;
      frame_done  <= fd_cond;
      if (fs_cond)     underrun <= 1'b0;
      else if (starve) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmos_dvp_tx.sv
// Self-checking bench for cmos_dvp_tx with a small frame geometry.
module tb_cmos_dvp_tx;
  import cmos_dvp_tx_pkg::*;

  localparam int H = 8, V = 4, VS = 4, VBP = 3, HB = 2, VFP = 3;
  localparam int LINE_B = 2 * H;
  localparam int FRAME_B = LINE_B * V;
  localparam int DROP_SLOT = 2 * H + 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_en = 1'b0;
  logic       pat_sel = 1'b0;
  logic       cmos_vsync, cmos_href, frame_start, frame_done, underrun;
  logic [7:0] cmos_data;

  always #5 clk = ~clk;

  cmos_dvp_tx_if pix_if();

  cmos_dvp_tx #(
    .H_DISP(H), .V_DISP(V), .VS_CYC(VS), .VBP_CYC(VBP), .HB_CYC(HB), .VFP_CYC(VFP)
  ) dut (
    .cmos_pclk   (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .pat_sel     (pat_sel),
    .pix         (pix_if),
    .cmos_vsync  (cmos_vsync),
    .cmos_href   (cmos_href),
    .cmos_data   (cmos_data),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .underrun    (underrun)
  );

  int tests = 0, fails = 0;

  // Monitor state (per-frame capture f_*, snapshot at frame_done d_*)
  int          cyc = 0, fs_cnt = 0, done_cnt = 0, vs_rise_cnt = 0, nz_low = 0;
  bit          prev_vs = 0, prev_href = 0, hs_prev = 0;
  int          f_vs_rise = 0, f_vs_fall = 0, f_fs_cyc = 0, f_ready = 0, slot = 0;
  int          f_rise[$], f_fall[$];
  logic [7:0]  f_bytes[$];
  logic [15:0] f_exp[$];
  bit          f_exp_under = 0;
  logic        fs_underrun = 1'b0;
  int          d_vs_rise = 0, d_vs_fall = 0, d_fs_cyc = 0, d_ready = 0, d_fdone_cyc = 0;
  int          d_rise[$], d_fall[$];
  logic [7:0]  d_bytes[$];
  logic [15:0] d_exp[$];
  bit          d_exp_under = 0;
  logic        d_underrun = 1'b0;
  int          last_fall = 0;

  // Upstream driver: 0 idle, 1 counting always valid, 2 counting with one drop, 3 random
  int          drv_mode = 0;
  logic [15:0] cur_data = 16'h0000;
  bit          valid = 0;

  function automatic logic [15:0] bar_rgb(input int b);
    case (b)
      0: bar_rgb = 16'hFFFF; 1: bar_rgb = 16'hFFE0; 2: bar_rgb = 16'h07FF; 3: bar_rgb = 16'h07E0;
      4: bar_rgb = 16'hF81F; 5: bar_rgb = 16'hF800; 6: bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
  endfunction

  initial begin : monitor
    pix_if.pix_valid = 1'b0;
    pix_if.pix_data  = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_vs = 0; prev_href = 0; hs_prev = 0;
        pix_if.pix_valid = 1'b0;
      end else begin
        if (frame_start) begin
          fs_cnt++; f_fs_cyc = cyc; fs_underrun = underrun;
          f_rise.delete(); f_fall.delete(); f_bytes.delete(); f_exp.delete();
          f_exp_under = 0; f_ready = 0; slot = 0;
        end
        if (cmos_vsync && !prev_vs) begin vs_rise_cnt++; f_vs_rise = cyc; end
        if (!cmos_vsync && prev_vs) f_vs_fall = cyc;
        if (cmos_href && !prev_href) f_rise.push_back(cyc);
        if (!cmos_href && prev_href) f_fall.push_back(cyc);
        if (cmos_href) f_bytes.push_back(cmos_data);
        else if (cmos_data != 8'h00) nz_low++;
        prev_vs = cmos_vsync; prev_href = cmos_href;
        // Stream source and reference: each ready slot carries the held pixel or zero
        if (hs_prev) cur_data = (drv_mode == 3) ? 16'($urandom) : cur_data + 16'd1;
        hs_prev = 0;
        case (drv_mode)
          1:       valid = 1;
          2:       valid = (slot != DROP_SLOT);
          3:       valid = ($urandom_range(0, 3) != 0);
          default: valid = 0;
        endcase
        pix_if.pix_valid = valid;
        pix_if.pix_data  = cur_data;
        if (pix_if.pix_ready) begin
          f_exp.push_back(valid ? cur_data : 16'h0000);
          if (!valid) f_exp_under = 1;
          slot++; f_ready++; hs_prev = valid;
        end
        if (frame_done) begin
          d_vs_rise = f_vs_rise; d_vs_fall = f_vs_fall; d_fs_cyc = f_fs_cyc; d_ready = f_ready;
          d_rise = f_rise; d_fall = f_fall; d_bytes = f_bytes; d_exp = f_exp;
          d_exp_under = f_exp_under; d_underrun = underrun; d_fdone_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int n0, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > n0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_fs(input int n0, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (fs_cnt > n0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    int vr;
    #2 rst_n = 1'b0;
    tx_en = 1'b0; pat_sel = 1'b0; drv_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (cmos_vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync: got %b want 0", cmos_vsync); end
    tests++; if (cmos_href !== 1'b0) begin fails++; $display("FAIL reset_href: got %b want 0", cmos_href); end
    tests++; if (cmos_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", cmos_data); end
    tests++; if (pix_if.pix_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", pix_if.pix_ready); end
    tests++; if (frame_start !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL reset_pulses: got %b%b want 00", frame_start, frame_done); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    rst_n = 1'b1;
    vr = vs_rise_cnt;
    repeat (10) @(posedge clk);
    #1;
    tests++; if (vs_rise_cnt != vr) begin fails++; $display("FAIL idle_no_vsync: got %0d rises want 0", vs_rise_cnt - vr); end
  endtask

  task automatic test_colorbar();
    bit ok; int n, errs, gap_err, len_err;
    logic [15:0] c;
    cur_data = 16'h0100; drv_mode = 1; pat_sel = 1'b1; tx_en = 1'b1;
    n = fs_cnt;
    wait_fs(n, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bars_start: got no frame_start want one"); end
    pat_sel = 1'b0;  // must not affect this frame
    n = done_cnt;
    wait_done(n, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL bars_done: got no frame_done want one"); end
    tests++; if (d_vs_fall - d_vs_rise != VS) begin fails++; $display("FAIL vsync_width: got %0d want %0d", d_vs_fall - d_vs_rise, VS); end
    tests++; if (d_fs_cyc != d_vs_rise) begin fails++; $display("FAIL fstart_align: got cycle %0d want %0d", d_fs_cyc, d_vs_rise); end
    tests++; if (d_rise.size() != V || d_fall.size() != V) begin fails++; $display("FAIL bars_lines: got %0d/%0d want %0d", d_rise.size(), d_fall.size(), V); end
    if (d_rise.size() > 0) begin
      tests++; if (d_rise[0] - d_vs_fall != VBP) begin fails++; $display("FAIL vbp: got %0d want %0d", d_rise[0] - d_vs_fall, VBP); end
    end
    gap_err = 0; len_err = 0;
    for (int l = 0; l < d_rise.size() && l < d_fall.size(); l++) begin
      if (d_fall[l] - d_rise[l] != LINE_B) len_err++;
      if (l + 1 < d_rise.size() && d_rise[l+1] - d_fall[l] != HB) gap_err++;
    end
    tests++; if (len_err != 0) begin fails++; $display("FAIL href_len: got %0d bad lines want 0", len_err); end
    tests++; if (gap_err != 0) begin fails++; $display("FAIL hblank: got %0d bad gaps want 0", gap_err); end
    errs = 0;
    for (int k = 0; k < FRAME_B; k++) begin
      c = bar_rgb(((k / 2) % H) * 8 / H);
      if (k >= d_bytes.size() || d_bytes[k] !== ((k % 2 == 0) ? c[15:8] : c[7:0])) errs++;
    end
    tests++; if (errs != 0 || d_bytes.size() != FRAME_B) begin fails++; $display("FAIL bars_bytes: got %0d bad of %0d want 0 of %0d", errs, d_bytes.size(), FRAME_B); end
    if (d_fall.size() == V) begin
      tests++; if (d_fdone_cyc != d_fall[V-1]) begin fails++; $display("FAIL fdone_bars: got cycle %0d want %0d", d_fdone_cyc, d_fall[V-1]); end
      last_fall = d_fall[V-1];
    end
    tests++; if (d_ready != 0) begin fails++; $display("FAIL bars_ready: got %0d want 0", d_ready); end
    tests++; if (nz_low != 0) begin fails++; $display("FAIL data_idle: got %0d nonzero want 0", nz_low); end
  endtask

  task automatic test_stream();
    bit ok; int n, errs;
    logic [15:0] p;
    n = done_cnt;
    wait_done(n, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stream_done: got no frame_done want one"); end
    tests++; if (d_vs_rise - last_fall != VFP) begin fails++; $display("FAIL vfp: got %0d want %0d", d_vs_rise - last_fall, VFP); end
    errs = 0;
    for (int k = 0; k < FRAME_B; k++) begin
      p = 16'h0100 + 16'(k / 2);
      if (k >= d_bytes.size() || d_bytes[k] !== ((k % 2 == 0) ? p[15:8] : p[7:0])) errs++;
    end
    tests++; if (errs != 0 || d_bytes.size() != FRAME_B) begin fails++; $display("FAIL stream_bytes: got %0d bad of %0d want 0 of %0d", errs, d_bytes.size(), FRAME_B); end
    tests++; if (d_ready != H * V) begin fails++; $display("FAIL stream_ready: got %0d want %0d", d_ready, H * V); end
    tests++; if (d_underrun !== 1'b0) begin fails++; $display("FAIL stream_underrun: got %b want 0", d_underrun); end
    if (d_bytes.size() == FRAME_B && d_fall.size() == V) begin
      tests++; if (d_bytes[FRAME_B-1] !== 8'h1F) begin fails++; $display("FAIL stream_last: got %h want 1f", d_bytes[FRAME_B-1]); end
      tests++; if (d_fdone_cyc != d_fall[V-1]) begin fails++; $display("FAIL fdone_stream: got cycle %0d want %0d", d_fdone_cyc, d_fall[V-1]); end
    end
  endtask

  task automatic test_underrun();
    bit ok; int n, errs;
    logic [15:0] p;
    drv_mode = 2; cur_data = 16'h0100;
    n = done_cnt;
    wait_done(n, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL drop_done: got no frame_done want one"); end
    errs = 0;
    for (int k = 0; k < FRAME_B; k++) begin
      if (k / 2 < DROP_SLOT)       p = 16'h0100 + 16'(k / 2);
      else if (k / 2 == DROP_SLOT) p = 16'h0000;
      else                         p = 16'h0100 + 16'(k / 2 - 1);
      if (k >= d_bytes.size() || d_bytes[k] !== ((k % 2 == 0) ? p[15:8] : p[7:0])) errs++;
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL drop_bytes: got %0d bad want 0", errs); end
    tests++; if (d_underrun !== 1'b1) begin fails++; $display("FAIL drop_underrun: got %b want 1", d_underrun); end
    drv_mode = 1;
    n = fs_cnt;
    wait_fs(n, 20, ok);
    tests++; if (!ok || fs_underrun !== 1'b0) begin fails++; $display("FAIL underrun_clear: got %b want 0", fs_underrun); end
  endtask

  task automatic test_random();
    bit ok; int n, errs;
    drv_mode = 3;
    for (int f = 0; f < 3; f++) begin
      n = done_cnt;
      wait_done(n, 200, ok);
      errs = 0;
      for (int k = 0; k < FRAME_B; k++)
        if (k / 2 >= d_exp.size() || k >= d_bytes.size() ||
            d_bytes[k] !== ((k % 2 == 0) ? d_exp[k/2][15:8] : d_exp[k/2][7:0])) errs++;
      tests++; if (!ok || errs != 0) begin fails++; $display("FAIL rand_bytes[%0d]: got %0d bad want 0", f, errs); end
      tests++; if (d_underrun !== logic'(d_exp_under)) begin fails++; $display("FAIL rand_underrun[%0d]: got %b want %b", f, d_underrun, d_exp_under); end
    end
  endtask

  task automatic test_txen_stop();
    bit ok; int n, vr, fsn;
    n = fs_cnt;
    wait_fs(n, 100, ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (f_rise.size() >= 2) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL stop_line1: got no line 1 want one"); end
    tx_en = 1'b0;
    n = done_cnt;
    wait_done(n, 200, ok);
    tests++; if (!ok || d_rise.size() != V) begin fails++; $display("FAIL stop_lines: got %0d want %0d", d_rise.size(), V); end
    vr = vs_rise_cnt; fsn = fs_cnt;
    repeat (40) @(posedge clk);
    #1;
    tests++; if (vs_rise_cnt != vr || fs_cnt != fsn || cmos_vsync !== 1'b0) begin fails++; $display("FAIL stop_idle: got %0d rises want 0", vs_rise_cnt - vr); end
  endtask

  task automatic test_reset_midline();
    bit ok; int n, vr, errs;
    logic [15:0] c;
    drv_mode = 1; cur_data = 16'h0100; pat_sel = 1'b0; tx_en = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (pix_if.pix_ready === 1'b1 && cmos_href === 1'b1) begin ok = 1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL rst_midline: got no active line want one"); end
    #2 rst_n = 1'b0; tx_en = 1'b0;
    #1;
    tests++; if ({cmos_vsync, cmos_href, pix_if.pix_ready} !== 3'b000 || cmos_data !== 8'h00) begin
      fails++; $display("FAIL rst_async: got vs%b hr%b rdy%b d%h want all 0", cmos_vsync, cmos_href, pix_if.pix_ready, cmos_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    vr = vs_rise_cnt;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (vs_rise_cnt != vr || cmos_href !== 1'b0) begin fails++; $display("FAIL rst_no_resume: got %0d rises want 0", vs_rise_cnt - vr); end
    pat_sel = 1'b1; tx_en = 1'b1;
    n = done_cnt;
    wait_done(n, 200, ok);
    errs = 0;
    for (int k = 0; k < FRAME_B; k++) begin
      c = bar_rgb(((k / 2) % H) * 8 / H);
      if (k >= d_bytes.size() || d_bytes[k] !== ((k % 2 == 0) ? c[15:8] : c[7:0])) errs++;
    end
    tests++; if (!ok || errs != 0 || d_rise.size() != V) begin fails++; $display("FAIL rst_restart: got %0d bad bytes, %0d lines want 0, %0d", errs, d_rise.size(), V); end
    if (d_rise.size() > 0) begin
      tests++; if (d_rise[0] - d_vs_fall != VBP) begin fails++; $display("FAIL rst_vbp: got %0d want %0d", d_rise[0] - d_vs_fall, VBP); end
    end
    tx_en = 1'b0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    test_reset();
    test_colorbar();
    test_stream();
    test_underrun();
    test_random();
    test_txen_stop();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
